// File: rtl/dmem_if.sv
// Request/response bus between a data-memory initiator and responder.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
//
// Signals: req_valid/req_ready/req_we/req_addr/req_wdata/req_wstrb carry a
// request toward the responder; rsp_valid/rsp_ready/rsp_rdata/rsp_err carry
// the response back. "master" is the initiator view, "slave" the responder view.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with byte strobes and error detection.
// Latency: request accepted on edge N shows rsp_valid sampled high at edge N+1+LATENCY.
// Backpressure: one transaction at a time; req_ready only in IDLE, response held until rsp_ready.
//
// Ports: clk, rst (synchronous, active-high), bus (dmem_if.slave request and
// response channels), busy (high whenever the FSM is not in IDLE).
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus,
    output logic   busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t      state;
    logic [3:0]  cnt;
    req_t        req_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem [DEPTH];

    req_t        in_req;
    req_t        acc;
    logic        do_access;
    logic        acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0] rd_word;
    logic [31:0] wr_word;

    assign in_req = '{we: bus.req_we, addr: bus.req_addr,
                      wdata: bus.req_wdata, wstrb: bus.req_wstrb};

    // With zero latency the access happens on the accept edge, so it must use
    // the live bus fields; otherwise it uses the fields captured at accept.
    assign acc = (state == IDLE) ? in_req : req_q;

    generate
        if (LATENCY == 0) begin : g_lat0
            assign do_access = (state == IDLE) && bus.req_valid;
        end else begin : g_latn
            assign do_access = (state == WAIT) && (cnt == 4'd1);
        end
    endgenerate

    // Misaligned, or any address bit at or above the array size set.
    assign acc_err = (acc.addr[1:0] != 2'b00) || (|acc.addr[31:AW+2]);
    assign acc_idx = acc.addr[AW+1:2];
    assign rd_word = mem[acc_idx];

    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (acc.wstrb[i]) begin
                wr_word[8*i +: 8] = acc.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q <= in_req;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            cnt   <= 4'(LATENCY);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // The access edge also loads the response registers, so the
            // response is visible in the cycle right after the access.
            if (do_access) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= acc_err;
                rsp_rdata_q <= (acc_err || acc.we) ? 32'd0 : rd_word;
                if (!acc_err && acc.we) begin
                    mem[acc_idx] <= wr_word;
                end
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-level reference model, random traffic,
// directed corner cases, and a second zero-latency instance for back-to-back timing.
// Monitor process pops expected responses independently of the stimulus driver.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, busy0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    dmem_if b ();
    dmem_if b0 ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .bus(b), .busy(busy)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(b0), .busy(busy0)
    );

    assign b0.rsp_ready = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory kept as bytes, independent of any word organisation.
    logic [7:0] ref_bytes [4*DEPTH];
    exp_t       q[$];
    exp_t       cur;
    bit         cur_active  = 0;
    bit         expect_idle = 0;
    bit         force_hold  = 0;
    bit         rand_ready  = 1;
    int         hold_left   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model_access(input bit we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] strb,
                                          input int acc);
        exp_t e;
        e.acc   = acc;
        e.rdata = 32'd0;
        e.err   = (addr % 4 != 0) || (addr >= 4*DEPTH);
        if (!e.err) begin
            for (int i = 0; i < 4; i++) begin
                if (we) begin
                    if (strb[i]) ref_bytes[addr+i] = wdata[8*i +: 8];
                end else begin
                    e.rdata[8*i +: 8] = ref_bytes[addr+i];
                end
            end
        end
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4*DEPTH; i++) ref_bytes[i] = 8'h00;
        q.delete();
    endfunction

    // Monitor: on each falling edge compare whatever the DUT presents against
    // the head of the expected queue, and choose rsp_ready for the next edge.
    always @(negedge clk) begin
        if (rst) begin
            cur_active  = 0;
            expect_idle = 0;
            hold_left   = 0;
            b.rsp_ready = 1'b0;
        end else begin
            if (expect_idle) begin
                check("idle_after_rsp_ready", {30'd0, b.req_ready, busy}, 32'h2);
                expect_idle = 0;
            end
            if (b.rsp_valid) begin
                if (!cur_active) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_rsp actual=rsp_valid required=no_response (cycle %0d)", cyc);
                    end else begin
                        cur = q.pop_front();
                        cur_active = 1;
                        check("rsp_latency", cyc, cur.acc + LAT);
                        if (force_hold) begin
                            hold_left  = 5;
                            force_hold = 0;
                        end else begin
                            hold_left = rand_ready ? $urandom_range(0, 3) : 0;
                        end
                    end
                end
                if (cur_active) begin
                    check("rsp_rdata", b.rsp_rdata, cur.rdata);
                    check("rsp_err", {31'd0, b.rsp_err}, {31'd0, cur.err});
                    check("req_ready_in_resp", {31'd0, b.req_ready}, 32'd0);
                    check("busy_in_resp", {31'd0, busy}, 32'd1);
                end
                if (hold_left > 0) begin
                    b.rsp_ready = 1'b0;
                    hold_left--;
                end else begin
                    b.rsp_ready = 1'b1;
                    if (cur_active) expect_idle = 1;
                    cur_active = 0;
                end
            end else begin
                if (cur_active) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_dropped actual=rsp_valid0 required=rsp_valid1 (cycle %0d)", cyc);
                    cur_active = 0;
                end
                check("idle_rsp_outputs", {b.rsp_err, b.rsp_rdata[30:0]} | {31'd0, b.rsp_rdata[31]}, 32'd0);
                b.rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit track);
        int t;
        exp_t e;
        @(negedge clk);
        b.req_valid = 1'b1;
        b.req_we    = we;
        b.req_addr  = addr;
        b.req_wdata = wdata;
        b.req_wstrb = strb;
        t = 0;
        while (!b.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!b.req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout actual=req_ready0 required=req_ready1 addr=%h", addr);
            b.req_valid = 1'b0;
            return;
        end
        if (track) begin
            e = model_access(we, addr, wdata, strb, cyc + 1);
            q.push_back(e);
        end
        @(negedge clk);
        // Scramble the inputs: the transaction in flight must not notice.
        b.req_valid = 1'b0;
        b.req_we    = 1'($urandom);
        b.req_addr  = $urandom;
        b.req_wdata = $urandom;
        b.req_wstrb = 4'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || cur_active || !b.req_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (t >= 500) begin
            fails++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a0_addr  [4];
        logic [31:0] a0_wdata [4];
        logic [3:0]  a0_strb  [4];
        bit          a0_we    [4];
        logic [31:0] a0_rdata [4];
        int          acc0     [4];
        int          idx, ridx;
        logic [31:0] addr;

        b.req_valid = 0; b.req_we = 0; b.req_addr = 0; b.req_wdata = 0; b.req_wstrb = 0;
        b.rsp_ready = 0;
        b0.req_valid = 0; b0.req_we = 0; b0.req_addr = 0; b0.req_wdata = 0; b0.req_wstrb = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_req_ready", {31'd0, b.req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, b.rsp_valid}, 32'd0);
        check("reset_rsp_rdata", b.rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, b.rsp_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Full-word store then load
        send(1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
        send(0, 32'h10, 32'h0, 4'h0, 1);
        drain();

        // Strobed partial store merges into the previous word
        send(1, 32'h20, 32'h11223344, 4'hF, 1);
        send(1, 32'h20, 32'hAABBCCDD, 4'h5, 1);
        send(0, 32'h20, 32'h0, 4'h0, 1);
        // wstrb=0 store is a legal no-op
        send(1, 32'h20, 32'hFFFFFFFF, 4'h0, 1);
        send(0, 32'h20, 32'h0, 4'h0, 1);
        drain();

        // Error cases: misaligned, first address past the array, store past it
        send(0, 32'h02, 32'h0, 4'h0, 1);
        send(0, 32'h400, 32'h0, 4'h0, 1);
        send(1, 32'h400, 32'h5A5A5A5A, 4'hF, 1);
        send(1, 32'h13, 32'h5A5A5A5A, 4'hF, 1);
        send(0, 32'h3FC, 32'h0, 4'h0, 1);
        drain();

        // Response held off for 5 cycles
        force_hold = 1;
        send(0, 32'h10, 32'h0, 4'h0, 1);
        drain();

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 9))
                0: addr = 32'($urandom_range(0, 4*DEPTH - 1)) | 32'($urandom_range(1, 3));
                1: addr = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(4*DEPTH, 4*DEPTH + 64)) : $urandom;
                2, 3, 4: addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
                default: addr = 32'($urandom_range(0, 15)) << 2;
            endcase
            send(1'($urandom), addr, $urandom, 4'($urandom), 1);
        end
        drain();

        // Read back the whole array
        rand_ready = 0;
        for (int w = 0; w < DEPTH; w++) send(0, 32'(w) << 2, 32'h0, 4'h0, 1);
        drain();
        rand_ready = 1;

        // Reset while a store is waiting: aborted, no response, memory cleared
        send(1, 32'h8, 32'h12345678, 4'hF, 0);
        check("wait_state_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_req_ready", {31'd0, b.req_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, b.rsp_valid}, 32'd0);
        repeat (5) @(negedge clk);
        send(0, 32'h8, 32'h0, 4'h0, 1);
        send(0, 32'h10, 32'h0, 4'h0, 1);
        drain();

        // Zero-latency instance: back-to-back requests, rsp_ready tied high
        a0_we[0] = 1; a0_addr[0] = 32'h4; a0_wdata[0] = 32'hCAFEF00D; a0_strb[0] = 4'hF; a0_rdata[0] = 32'h0;
        a0_we[1] = 0; a0_addr[1] = 32'h4; a0_wdata[1] = 32'h0;        a0_strb[1] = 4'h0; a0_rdata[1] = 32'hCAFEF00D;
        a0_we[2] = 1; a0_addr[2] = 32'h4; a0_wdata[2] = 32'h12345678; a0_strb[2] = 4'h3; a0_rdata[2] = 32'h0;
        a0_we[3] = 0; a0_addr[3] = 32'h4; a0_wdata[3] = 32'h0;        a0_strb[3] = 4'h0; a0_rdata[3] = 32'hCAFE5678;
        idx = 0;
        ridx = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (b0.rsp_valid) begin
                if (ridx < 4) begin
                    check("lat0_rsp_cycle", cyc, acc0[ridx]);
                    check("lat0_rdata", b0.rsp_rdata, a0_rdata[ridx]);
                    check("lat0_err", {31'd0, b0.rsp_err}, 32'd0);
                end
                ridx++;
            end
            if (b0.req_ready) begin
                if (idx < 4) begin
                    b0.req_valid = 1'b1;
                    b0.req_we    = a0_we[idx];
                    b0.req_addr  = a0_addr[idx];
                    b0.req_wdata = a0_wdata[idx];
                    b0.req_wstrb = a0_strb[idx];
                    acc0[idx]    = cyc + 1;
                    if (idx > 0) check("lat0_accept_spacing", acc0[idx] - acc0[idx-1], 32'd2);
                    idx++;
                end else begin
                    b0.req_valid = 1'b0;
                end
            end
        end
        check("lat0_rsp_count", ridx, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, meaning number of 32-bit words of storage (power of two, 16..1024).
REQ-002 Parameter LATENCY, default 2, meaning wait cycles between request accept and access (0..15).
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_wstrb  input  4  byte-lane enables; bit i writes byte i (bits 8i+7:8i).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  access error flag, valid while rsp_valid=1.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1.
REQ-018 On acceptance the block SHALL register req_we, req_addr, req_wdata and req_wstrb; later input changes SHALL have no effect on that transaction.
REQ-019 On acceptance with LATENCY>0 the block SHALL load the wait counter with LATENCY and enter WAIT; with LATENCY=0 it SHALL perform the access on the same edge and enter RESP.
REQ-020 In WAIT the counter SHALL decrement once per cycle; the access SHALL be performed on the edge where the counter equals 1, with transition to RESP on that same edge.
REQ-021 Latency: request accepted on edge N SHALL produce rsp_valid=1 from edge N+1+LATENCY.
REQ-022 Word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-023 An error SHALL be flagged when req_addr[1:0]!=0 or req_addr >= 4*DEPTH.
REQ-024 On error, storage SHALL be unmodified, rsp_rdata SHALL be 0 and rsp_err SHALL be 1.
REQ-025 A valid store SHALL update only the strobed byte lanes; wstrb=0 SHALL be a legal no-op store that returns rsp_err=0.
REQ-026 A valid load SHALL return the full word, including any store completed by an earlier transaction.
REQ-027 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1; the FSM SHALL then return to IDLE on that edge, and rsp_valid SHALL drop in the next cycle.
REQ-028 A new request SHALL NOT be accepted in the cycle in which a response completes; the minimum spacing between acceptances is LATENCY+2 cycles.
REQ-029 Outside RESP, rsp_valid, rsp_err and rsp_rdata SHALL be 0.

Reset
REQ-030 While rst=1 at an edge: FSM to IDLE, counter to 0, registered request fields to 0, all storage words to 0x00000000.
REQ-031 After reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no response; a store not yet performed SHALL be discarded.
REQ-033 rst SHALL take priority over every handshake on the same edge.

Verification
REQ-034 Store 0xDEADBEEF to addr 0x10 with wstrb=0xF, then load addr 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid first seen 3 cycles after acceptance (LATENCY=2).
REQ-035 Store 0x11223344 with wstrb=0xF, then store 0xAABBCCDD with wstrb=0x5 to addr 0x20, then load -> 0x11BB33DD.
REQ-036 Load addr 0x02 and load addr 0x400 (DEPTH=256) -> rsp_err=1 and rsp_rdata=0; store to 0x400 leaves the whole array unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0 throughout; on the rsp_ready=1 edge, IDLE is entered.
REQ-038 Assert rst in WAIT during a store to 0x8 -> IDLE on the next cycle, no response, and a subsequent load of 0x8 returns 0.
REQ-039 With LATENCY=0, back-to-back requests and rsp_ready tied to 1 -> one acceptance every 2 cycles; each response appears the cycle after acceptance.
